// File: rtl/axicb_pkg.sv
// axicb_pkg: shared constants, arbiter state type and helpers for the axicb write switch
package axicb_pkg;
  localparam int MST_NB = 4;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic int bresp_lsb(int id_w);
    return id_w;
  endfunction
  function automatic logic [1:0] oh2idx(logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/axicb_round_robin.sv
// axicb_round_robin: one-hot grant to the first requester at or after the pointer
module axicb_round_robin (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] grant_o
);
  // scan from farthest to nearest so the nearest requester is the last write
  always_comb begin
    grant_o = '0;
    for (int k = 3; k >= 0; k--)
      if (req_i[ptr_i + 2'(k)]) grant_o = 4'b1 << (ptr_i + 2'(k));
  end
endmodule

// File: rtl/axicb_scfifo.sv
// axicb_scfifo: single-clock FIFO with optional pass-through and an almost-full flag
module axicb_scfifo #(
  parameter int PASS_THRU  = 0,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 2
)(
  input  logic                  aclk,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  output logic                  afull,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  pop,
  output logic                  empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_q, rd_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  bypass, wr_en, rd_en;
  assign bypass   = (PASS_THRU != 0) && (cnt_q == '0);
  assign empty    = bypass ? !push : (cnt_q == '0);
  assign data_out = bypass ? data_in : mem_q[rd_q];
  assign wr_en    = push && (cnt_q != FULL_CNT) && !(bypass && pop);
  assign rd_en    = pop && !empty && !bypass;
  assign afull    = cnt_q >= AFULL_CNT;
  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(rd_en);
    end
  end
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_q] <= data_in;
  end
endmodule

// File: rtl/axicb_mst_switch_wr.sv
// axicb_mst_switch_wr: arbitrates AW from four masters, orders W by grant FIFO, routes B by ID tag
module axicb_mst_switch_wr
  import axicb_pkg::*;
#(
  parameter int                 AXI_ADDR_W   = 8,
  parameter int                 AXI_ID_W     = 8,
  parameter int                 MST_NB       = 4,
  parameter logic [AXI_ID_W-1:0] MST0_ID_MASK = 'h10,
  parameter logic [AXI_ID_W-1:0] MST1_ID_MASK = 'h20,
  parameter logic [AXI_ID_W-1:0] MST2_ID_MASK = 'h40,
  parameter logic [AXI_ID_W-1:0] MST3_ID_MASK = 'h80,
  parameter logic [AXI_ID_W-1:0] ID_SEL_MASK  = 'hF0,
  parameter int                 WFIFO_AW     = 3,
  parameter int                 AWCH_W       = 16,
  parameter int                 WCH_W        = 8,
  parameter int                 BCH_W        = 10
)(
  input  logic                     aclk,
  input  logic                     srst,
  input  logic [MST_NB-1:0]        i_awvalid,
  output logic [MST_NB-1:0]        i_awready,
  input  logic [MST_NB*AWCH_W-1:0] i_awch,
  input  logic [MST_NB-1:0]        i_wvalid,
  output logic [MST_NB-1:0]        i_wready,
  input  logic [MST_NB-1:0]        i_wlast,
  input  logic [MST_NB*WCH_W-1:0]  i_wch,
  output logic [MST_NB-1:0]        i_bvalid,
  input  logic [MST_NB-1:0]        i_bready,
  output logic [BCH_W-1:0]         i_bch,
  output logic                     o_awvalid,
  input  logic                     o_awready,
  output logic [AWCH_W-1:0]        o_awch,
  output logic                     o_wvalid,
  input  logic                     o_wready,
  output logic                     o_wlast,
  output logic [WCH_W-1:0]         o_wch,
  input  logic                     o_bvalid,
  output logic                     o_bready,
  input  logic [BCH_W-1:0]         o_bch,
  output logic                     b_misroute
);
  arb_state_t                state_q;
  logic [3:0]                grant_q, rr_grant, bmatch, bsel;
  logic [1:0]                ptr_q, gidx, head;
  logic                      aw_hs, wf_pop, wf_empty, wf_afull;
  logic [AXI_ID_W-1:0]       bid;
  logic [3:0][AXI_ID_W-1:0]  tags;
  axicb_round_robin u_rr (
    .req_i   (i_awvalid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant)
  );
  assign gidx      = oh2idx(grant_q);
  assign o_awvalid = (state_q == GRANT) && |(i_awvalid & grant_q);
  assign o_awch    = i_awch[gidx*AWCH_W +: AWCH_W];
  assign i_awready = (state_q == GRANT) ? grant_q & {4{o_awready}} : '0;
  assign aw_hs     = o_awvalid & o_awready;
  // almost-full gates new grants so a held grant can always push its index
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else if (state_q == IDLE) begin
      if (|i_awvalid && !wf_afull) begin
        state_q <= GRANT;
        grant_q <= rr_grant;
      end
    end else if (aw_hs) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= gidx + 2'd1;
    end
  end
  axicb_scfifo #(
    .PASS_THRU  (0),
    .ADDR_WIDTH (WFIFO_AW),
    .DATA_WIDTH (2)
  ) u_wfifo (
    .aclk     (aclk),
    .srst     (srst),
    .data_in  (gidx),
    .push     (aw_hs),
    .afull    (wf_afull),
    .data_out (head),
    .pop      (wf_pop),
    .empty    (wf_empty)
  );
  assign o_wvalid = !wf_empty && i_wvalid[head];
  assign o_wch    = i_wch[head*WCH_W +: WCH_W];
  assign o_wlast  = i_wlast[head];
  assign i_wready = wf_empty ? '0 : 4'(o_wready) << head;
  assign wf_pop   = o_wvalid & o_wready & o_wlast;
  assign tags = {MST3_ID_MASK, MST2_ID_MASK, MST1_ID_MASK, MST0_ID_MASK};
  assign bid  = o_bch[AXI_ID_W-1:0];
  always_comb begin
    bmatch = '0;
    for (int i = 0; i < 4; i++) bmatch[i] = (bid & ID_SEL_MASK) == tags[i];
  end
  assign bsel       = bmatch & (~bmatch + 4'd1);
  assign i_bvalid   = o_bvalid ? bsel : '0;
  assign o_bready   = |bmatch ? |(i_bready & bsel) : 1'b1;
  assign b_misroute = o_bvalid & ~|bmatch;
  assign i_bch      = o_bch;
endmodule

// File: tb/tb_axicb_mst_switch_wr.sv
// tb_axicb_mst_switch_wr: scenario tasks with queue-based expectations for the write switch
module tb_axicb_mst_switch_wr;
  localparam int AWCH_W = 16, WCH_W = 8, BCH_W = 10;
  logic aclk = 1'b0, srst;
  logic [3:0] i_awvalid, i_awready, i_wvalid, i_wready, i_wlast, i_bvalid, i_bready;
  logic [4*AWCH_W-1:0] i_awch;
  logic [4*WCH_W-1:0] i_wch;
  logic [BCH_W-1:0] i_bch, o_bch;
  logic o_awvalid, o_awready, o_wvalid, o_wready, o_wlast, o_bvalid, o_bready, b_misroute;
  logic [AWCH_W-1:0] o_awch;
  logic [WCH_W-1:0] o_wch;
  int checks = 0, failures = 0;
  logic [AWCH_W-1:0] exp_aw[$];
  int exp_w[$];
  always #5 aclk = ~aclk;
  axicb_mst_switch_wr dut (
    .aclk(aclk), .srst(srst),
    .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
    .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch), .b_misroute(b_misroute)
  );
  function automatic logic [AWCH_W-1:0] awch_of(int m, logic [7:0] a);
    logic [7:0] tag;
    tag = 8'h10 << m;
    return {tag, a};
  endfunction
  task automatic set_aw(int m, logic v, logic [7:0] a);
    i_awvalid[m] = v;
    i_awch[m*AWCH_W +: AWCH_W] = awch_of(m, a);
  endtask
  task automatic set_w(int m, logic v, logic l, logic [7:0] d);
    i_wvalid[m] = v;
    i_wlast[m] = l;
    i_wch[m*WCH_W +: WCH_W] = d;
  endtask
  task automatic test_reset;
    srst = 1'b1;
    i_awvalid = '0; i_awch = '0; i_wvalid = '0; i_wlast = '0; i_wch = '0; i_bready = '0;
    o_awready = 1'b0; o_wready = 1'b0; o_bvalid = 1'b0; o_bch = '0;
    repeat (3) @(negedge aclk);
    i_wvalid = 4'hF;
    #1;
    checks++; if (o_awvalid !== 1'b0) begin failures++; $display("FAIL reset_awvalid got=%b exp=0", o_awvalid); end
    checks++; if (i_awready !== 4'b0) begin failures++; $display("FAIL reset_awready got=%b exp=0000", i_awready); end
    checks++; if (o_wvalid !== 1'b0) begin failures++; $display("FAIL reset_wvalid got=%b exp=0", o_wvalid); end
    checks++; if (i_wready !== 4'b0) begin failures++; $display("FAIL reset_wready got=%b exp=0000", i_wready); end
    @(negedge aclk);
    srst = 1'b0; i_wvalid = '0;
  endtask
  task automatic test_arb;
    logic [AWCH_W-1:0] e;
    @(negedge aclk);
    o_awready = 1'b1;
    set_aw(0, 1'b1, 8'h11); set_aw(2, 1'b1, 8'h22);
    exp_aw.push_back(awch_of(0, 8'h11)); exp_aw.push_back(awch_of(2, 8'h22));
    exp_w.push_back(0); exp_w.push_back(2);
    #1;
    checks++; if (o_awvalid !== 1'b0) begin failures++; $display("FAIL arb_c0_awvalid got=%b exp=0", o_awvalid); end
    @(negedge aclk); #1;
    e = exp_aw.pop_front();
    checks++; if (o_awvalid !== 1'b1) begin failures++; $display("FAIL arb_c1_awvalid got=%b exp=1", o_awvalid); end
    checks++; if (i_awready !== 4'b0001) begin failures++; $display("FAIL arb_c1_awready got=%b exp=0001", i_awready); end
    checks++; if (o_awch !== e) begin failures++; $display("FAIL arb_c1_awch got=%h exp=%h", o_awch, e); end
    @(negedge aclk);
    set_aw(0, 1'b0, 8'h11);
    #1;
    checks++; if (o_awvalid !== 1'b0) begin failures++; $display("FAIL arb_c2_awvalid got=%b exp=0", o_awvalid); end
    @(negedge aclk); #1;
    e = exp_aw.pop_front();
    checks++; if (i_awready !== 4'b0100) begin failures++; $display("FAIL arb_c3_awready got=%b exp=0100", i_awready); end
    checks++; if (o_awch !== e) begin failures++; $display("FAIL arb_c3_awch got=%h exp=%h", o_awch, e); end
    @(negedge aclk);
    set_aw(2, 1'b0, 8'h22); o_awready = 1'b0;
  endtask
  task automatic test_w_order;
    int h;
    logic [3:0] er;
    @(negedge aclk);
    o_wready = 1'b1;
    set_w(2, 1'b1, 1'b0, 8'hB0);
    #1;
    h = exp_w[0]; er = 4'b1 << h;
    checks++; if (o_wvalid !== 1'b0) begin failures++; $display("FAIL worder_block_wvalid got=%b exp=0", o_wvalid); end
    checks++; if (i_wready !== er) begin failures++; $display("FAIL worder_block_wready got=%b exp=%b", i_wready, er); end
    @(negedge aclk);
    set_w(h, 1'b1, 1'b1, 8'hA0);
    #1;
    checks++; if (o_wvalid !== 1'b1 || o_wch !== 8'hA0 || o_wlast !== 1'b1) begin failures++; $display("FAIL worder_m0 got=%b/%h/%b exp=1/a0/1", o_wvalid, o_wch, o_wlast); end
    void'(exp_w.pop_front());
    h = exp_w[0]; er = 4'b1 << h;
    for (int b = 0; b < 4; b++) begin
      @(negedge aclk);
      set_w(0, 1'b0, 1'b0, 8'h00);
      set_w(h, 1'b1, b == 3, 8'hB0 + 8'(b));
      #1;
      checks++; if (o_wvalid !== 1'b1 || o_wch !== 8'hB0 + 8'(b) || o_wlast !== (b == 3)) begin failures++; $display("FAIL worder_m2_beat%0d got=%b/%h/%b", b, o_wvalid, o_wch, o_wlast); end
      checks++; if (i_wready !== er) begin failures++; $display("FAIL worder_m2_wready%0d got=%b exp=%b", b, i_wready, er); end
    end
    void'(exp_w.pop_front());
    @(negedge aclk);
    set_w(2, 1'b1, 1'b1, 8'hBF);
    #1;
    checks++; if (o_wvalid !== 1'b0 || i_wready !== 4'b0) begin failures++; $display("FAIL worder_empty got=%b/%b exp=0/0000", o_wvalid, i_wready); end
    @(negedge aclk);
    i_wvalid = '0; i_wlast = '0; o_wready = 1'b0;
  endtask
  task automatic test_fifo_full;
    int hs = 0, last = -1;
    logic got = 1'b0;
    logic [AWCH_W-1:0] e;
    @(negedge aclk);
    o_awready = 1'b1; o_wready = 1'b0;
    set_aw(1, 1'b1, 8'h30);
    for (int c = 1; c <= 20; c++) begin
      @(negedge aclk); #1;
      if (o_awvalid && o_awready) begin
        hs++; last = c;
        e = awch_of(1, 8'h30);
        checks++; if (o_awch !== e) begin failures++; $display("FAIL full_awch%0d got=%h exp=%h", hs, o_awch, e); end
      end
    end
    checks++; if (hs != 7) begin failures++; $display("FAIL full_grants got=%0d exp=7", hs); end
    checks++; if (last != 13) begin failures++; $display("FAIL full_b2b_last got=%0d exp=13", last); end
    @(negedge aclk);
    set_w(1, 1'b1, 1'b1, 8'hC0); o_wready = 1'b1;
    #1;
    checks++; if (o_wvalid !== 1'b1 || i_wready !== 4'b0010) begin failures++; $display("FAIL full_pop got=%b/%b exp=1/0010", o_wvalid, i_wready); end
    @(negedge aclk);
    set_w(1, 1'b0, 1'b0, 8'h00); o_wready = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      #1;
      if (o_awvalid && o_awready) got = 1'b1;
      else @(negedge aclk);
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL full_8th_grant got=%b exp=1", got); end
    @(negedge aclk);
    set_aw(1, 1'b0, 8'h30);
    set_w(1, 1'b1, 1'b1, 8'hC1); o_wready = 1'b1;
    for (int b = 0; b < 7; b++) begin
      #1;
      checks++; if (o_wvalid !== 1'b1 || o_wch !== 8'hC1) begin failures++; $display("FAIL full_drain%0d got=%b/%h exp=1/c1", b, o_wvalid, o_wch); end
      @(negedge aclk);
    end
    #1;
    checks++; if (o_wvalid !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", o_wvalid); end
    i_wvalid = '0; i_wlast = '0; o_wready = 1'b0; o_awready = 1'b0;
  endtask
  task automatic test_b_route;
    logic [BCH_W-1:0] b;
    @(negedge aclk);
    b = {2'b01, 8'h45};
    o_bvalid = 1'b1; o_bch = b; i_bready = 4'b0100;
    #1;
    checks++; if (i_bvalid !== 4'b0100) begin failures++; $display("FAIL b45_bvalid got=%b exp=0100", i_bvalid); end
    checks++; if (o_bready !== 1'b1 || b_misroute !== 1'b0) begin failures++; $display("FAIL b45_ready got=%b/%b exp=1/0", o_bready, b_misroute); end
    checks++; if (i_bch !== b) begin failures++; $display("FAIL b45_bch got=%h exp=%h", i_bch, b); end
    i_bready = 4'b1011;
    #1;
    checks++; if (o_bready !== 1'b0) begin failures++; $display("FAIL b45_stall got=%b exp=0", o_bready); end
    o_bch = {2'b10, 8'h05};
    #1;
    checks++; if (i_bvalid !== 4'b0 || o_bready !== 1'b1 || b_misroute !== 1'b1) begin failures++; $display("FAIL b05_misroute got=%b/%b/%b exp=0000/1/1", i_bvalid, o_bready, b_misroute); end
    o_bch = {2'b00, 8'h1F}; i_bready = 4'b0001;
    #1;
    checks++; if (i_bvalid !== 4'b0001 || o_bready !== 1'b1) begin failures++; $display("FAIL b1f got=%b/%b exp=0001/1", i_bvalid, o_bready); end
    o_bch = {2'b11, 8'h8A}; i_bready = 4'b0111;
    #1;
    checks++; if (i_bvalid !== 4'b1000 || o_bready !== 1'b0 || b_misroute !== 1'b0) begin failures++; $display("FAIL b8a got=%b/%b/%b exp=1000/0/0", i_bvalid, o_bready, b_misroute); end
    o_bvalid = 1'b0;
    #1;
    checks++; if (i_bvalid !== 4'b0 || b_misroute !== 1'b0) begin failures++; $display("FAIL b_idle got=%b/%b exp=0000/0", i_bvalid, b_misroute); end
    @(negedge aclk);
    i_bready = '0;
  endtask
  task automatic test_reset_mid;
    logic [AWCH_W-1:0] e;
    @(negedge aclk);
    o_awready = 1'b1; set_aw(2, 1'b1, 8'h42);
    @(negedge aclk);
    @(negedge aclk);
    set_aw(2, 1'b0, 8'h42); o_awready = 1'b0;
    set_aw(3, 1'b1, 8'h33); set_aw(1, 1'b1, 8'h13);
    set_w(2, 1'b1, 1'b0, 8'hD0);
    @(negedge aclk); #1;
    checks++; if (o_awvalid !== 1'b1 || o_wvalid !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b/%b exp=1/1", o_awvalid, o_wvalid); end
    srst = 1'b1;
    @(negedge aclk);
    srst = 1'b0; o_awready = 1'b1;
    exp_aw.push_back(awch_of(1, 8'h13));
    #1;
    checks++; if (o_awvalid !== 1'b0 || i_awready !== 4'b0) begin failures++; $display("FAIL rmid_aw got=%b/%b exp=0/0000", o_awvalid, i_awready); end
    checks++; if (o_wvalid !== 1'b0 || i_wready !== 4'b0) begin failures++; $display("FAIL rmid_fifo got=%b/%b exp=0/0000", o_wvalid, i_wready); end
    @(negedge aclk); #1;
    e = exp_aw.pop_front();
    checks++; if (i_awready !== 4'b0010 || o_awch !== e) begin failures++; $display("FAIL rmid_ptr0 got=%b/%h exp=0010/%h", i_awready, o_awch, e); end
    @(negedge aclk);
    i_awvalid = '0;
    i_wvalid = '0; set_w(1, 1'b1, 1'b1, 8'hE1); o_wready = 1'b1;
    #1;
    checks++; if (o_wvalid !== 1'b1 || o_wch !== 8'hE1) begin failures++; $display("FAIL rmid_w1 got=%b/%h exp=1/e1", o_wvalid, o_wch); end
    @(negedge aclk);
    i_wvalid = '0; i_wlast = '0; o_wready = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset;
    test_arb;
    test_w_order;
    test_fifo_full;
    test_b_route;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
